memory_access: RTL
==================

// Module: memory_access
// PURPOSE
//  Load/store stage directly downstream of the execute stage. Takes the ALU result (address or passthrough value),
//  store data and funct3 and runs one data-memory transaction per load/store over a req/gnt/rvalid bus.
//  Aligns and sign/zero-extends load data and hands a registered result to writeback. Non-memory ops pass through in one cycle.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles waited for gnt or rvalid before bus_err_o; 8-bit counter, range 1..255
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-low reset
//  flush_i         in   1   kill in-flight/held op (younger than a taken branch)
//  valid_i         in   1   execute stage output valid
//  ready_o         out  1   stage can accept (valid_i && ready_o = accept)
//  next_ready_i    in   1   writeback accepts this cycle
//  valid_o         out  1   result valid to writeback
//  mem_op_i        in   2   core_package::mem_op_e: MEM_NONE/MEM_LOAD/MEM_STORE
//  funct3_i        in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALU_result_i    in   32  address (load/store) or result (MEM_NONE)
//  rs2_i           in   32  store data
//  rd_i            in   5   destination register
//  pc_i            in   32  instruction PC
//  dmem_req_o      out  1   bus request
//  dmem_we_o       out  1   1 = store
//  dmem_be_o       out  4   byte enables
//  dmem_addr_o     out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata_o    out  32  store data replicated to lane
//  dmem_gnt_i      in   1   request accepted
//  dmem_rvalid_i   in   1   response valid (loads and stores)
//  dmem_rdata_i    in   32  read data
//  wb_data_o       out  32  load data or passthrough result
//  rd_o            out  5   destination register
//  pc_o            out  32  instruction PC
//  bus_err_o       out  1   timeout on this op (with valid_o); wb_data_o = 0, no writeback
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; valid_o, dmem_req_o, bus_err_o, kill flag, counter = 0;
//    wb_data_o, rd_o, pc_o = 0.
//  - States (core_package::mem_state_e): IDLE, REQ, RESP.
//    IDLE: accept on valid_i && ready_o; MEM_NONE -> output reg next cycle (1-cycle latency), stay IDLE;
//    load/store -> latch op, drive req, go REQ.
//    REQ: req/we/be/addr/wdata held stable until dmem_gnt_i; gnt -> RESP.
//    RESP: on dmem_rvalid_i load output reg (load: aligned data, store: 0), valid_o=1 -> IDLE.
//  - ready_o = (state==IDLE) && (!valid_o || next_ready_i). Min load/store latency: accept->valid_o = 3 cycles (gnt, rvalid same cycle as request).
//  - valid_o holds with stable data until next_ready_i; no new op overwrites an unconsumed result.
//  - Byte lanes: B be=4'b0001<<a[1:0], H be=4'b0011<<{a[1],1'b0}, W be=4'b1111; wdata = byte/half replicated across lanes.
//  - Load extract: shift rdata right by 8*a[1:0]; B/H sign-extend, BU/HU zero-extend; W unchanged.
//  - Timeout: counter clears on entering REQ/RESP and increments each waiting cycle; reaching TIMEOUT_CYCLES ->
//    drop req, valid_o=1, bus_err_o=1, -> IDLE. A late gnt/rvalid after timeout is ignored.
//  - flush_i: IDLE clears valid_o at next edge; in REQ/RESP sets kill flag, bus transaction still completes
//    (req never withdrawn before gnt), result discarded (valid_o stays 0). Flush with valid_i in same cycle: not accepted.
//  - Simultaneous next_ready_i and new accept: old result leaves, new op's result overwrites it.
// CONFIGURATION
//  MEMORY_ACCESS_MISALIGN_TRAP_EN defined: H with a[0]!=0 or W with a[1:0]!=0 issues no bus request;
//  completes in 1 cycle with valid_o=1, misalign_o=1 (extra port, 1 bit, reset 0), wb_data_o=0.
//  Not defined: port absent; low address bits forced to natural alignment (H: a[0]=0, W: a[1:0]=0).
// STRUCTURE
//  core_package: mem_op_e, mem_state_e, FUNCT3_LB..FUNCT3_LHU constants.
//  Sub-module load_data_align: combinational rdata/a[1:0]/funct3 -> extended 32-bit result; shared store-lane builder inside it.
// TESTING
//  - LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> wb_data_o=0xDEADBEEF, be=4'hF, valid_o 3 cycles after accept.
//  - LB addr 0x103, rdata 0x80FF_0000 -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  - SB addr 0x101, rs2=0x12345678 -> be=4'b0010, wdata=0x78787878, we=1; gnt held low 5 cycles -> req/addr stable throughout.
//  - next_ready_i=0 for 4 cycles after valid_o -> outputs stable, ready_o=0; MEM_NONE back-to-back with next_ready_i=1 -> 1 result/cycle.
//  - TIMEOUT_CYCLES=4, gnt never -> bus_err_o=1, valid_o=1 after 4 wait cycles; flush_i in RESP -> no valid_o for that op.
//  - With MEMORY_ACCESS_MISALIGN_TRAP_EN: LW addr 0x102 -> no dmem_req_o, misalign_o=1 next cycle; without: addr 0x100 issued.

Source files
------------

// File: rtl/core_package.sv
// Shared types and constants for the load/store stage: memory op encoding,
// load/store FSM states, funct3 size codes and the natural-alignment helpers.
package core_package;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Byte offset with the low bits forced to the access size's natural
  // alignment (bytes keep both bits, halves drop bit 0, words drop both).
  function automatic logic [1:0] natural_offset(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return addr_lo;
      2'b01:   return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // True when the address is not naturally aligned for the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Lane logic for the load/store stage. Purely combinational:
//  - load side: shifts read data down by the byte offset and sign/zero
//    extends according to funct3;
//  - store side: byte enables for the addressed lane(s) and store data
//    replicated across all lanes of the access size.
module load_data_align
  import core_package::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Load extraction: size and signedness from funct3, unknown codes act as word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    load_data_o = shifted;
    case (funct3_i)
      FUNCT3_LB:  load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LW:  load_data_o = shifted;
      FUNCT3_LBU: load_data_o = {24'h0, shifted[7:0]};
      FUNCT3_LHU: load_data_o = {16'h0, shifted[15:0]};
      default:    load_data_o = shifted;
    endcase
  end

  // Store lanes: byte enables follow the offset, data is replicated so the
  // memory picks the right lane regardless of which enable is set.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Load/store stage following execute. One data-memory transaction per
// load/store over a req/gnt/rvalid bus; non-memory ops pass through with
// one cycle of latency. Results are registered towards writeback and held
// until next_ready_i.
// Optional build macro MEMORY_ACCESS_MISALIGN_TRAP_EN: misaligned H/W
// accesses complete immediately with misalign_o=1 and no bus request.
// Without it, low address bits are forced to natural alignment.
module memory_access
  import core_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        next_ready_i,
  output logic        valid_o,
  input  mem_op_e     mem_op_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] pc_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic [31:0] pc_o,
  output logic        bus_err_o
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic        bus_err_q, bus_err_d;
  logic        kill_q, kill_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] sdata_q, sdata_d;

  logic        accept;
  logic        is_mem;
  logic        misalign_in;
  logic        start_bus;
  logic        kill_now;
  logic [7:0]  cnt_inc;
  logic        timeout;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wdata;

  // A flush in the same cycle as valid_i blocks the accept.
  assign ready_o   = (state_q == IDLE) && (!valid_q || next_ready_i);
  assign accept    = valid_i && ready_o && !flush_i;
  assign is_mem    = (mem_op_i == MEM_LOAD) || (mem_op_i == MEM_STORE);
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
  assign misalign_in = is_misaligned(funct3_i, ALU_result_i[1:0]);
`else
  assign misalign_in = 1'b0;
`endif
  assign start_bus = accept && is_mem && !misalign_in;
  assign kill_now  = kill_q || flush_i;
  assign cnt_inc   = cnt_q + 8'd1;
  assign timeout   = (cnt_inc == TIMEOUT_LIMIT);

  load_data_align u_align (
    .rdata_i      (dmem_rdata_i),
    .offset_i     (off_q),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .load_data_o  (ld_data),
    .be_o         (be),
    .wdata_o      (wdata)
  );

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      wb_data_q <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      bus_err_q <= 1'b0;
      kill_q    <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      sdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      bus_err_q <= bus_err_d;
      kill_q    <= kill_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      sdata_q   <= sdata_d;
    end
  end

  // Next state: IDLE -> REQ on a bus op, REQ -> RESP on gnt, back on rvalid or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_bus) state_d = REQ;
      REQ: begin
        if (dmem_gnt_i)   state_d = RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP: begin
        if (dmem_rvalid_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch ops, load results, track kill and wait counter.
  always_comb begin
    valid_d   = valid_q;
    wb_data_d = wb_data_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    bus_err_d = bus_err_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    off_d     = off_q;
    funct3_d  = funct3_q;
    sdata_d   = sdata_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          valid_d   = 1'b0;
          bus_err_d = 1'b0;
        end else if (accept) begin
          rd_d      = rd_i;
          pc_d      = pc_i;
          bus_err_d = 1'b0;
          if (!is_mem) begin
            valid_d   = 1'b1;
            wb_data_d = ALU_result_i;
          end else if (misalign_in) begin
            valid_d   = 1'b1;
            wb_data_d = '0;
          end else begin
            valid_d  = 1'b0;
            we_d     = (mem_op_i == MEM_STORE);
            addr_d   = ALU_result_i[31:2];
            off_d    = natural_offset(funct3_i, ALU_result_i[1:0]);
            funct3_d = funct3_i;
            sdata_d  = rs2_i;
            cnt_d    = '0;
            kill_d   = 1'b0;
          end
        end else if (next_ready_i) begin
          valid_d   = 1'b0;
          bus_err_d = 1'b0;
        end
      end
      REQ: begin
        kill_d = kill_now;
        if (dmem_gnt_i) begin
          cnt_d = '0;
        end else if (timeout) begin
          valid_d   = !kill_now;
          bus_err_d = !kill_now;
          wb_data_d = '0;
          kill_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        kill_d = kill_now;
        if (dmem_rvalid_i) begin
          valid_d   = !kill_now;
          wb_data_d = we_q ? 32'h0 : ld_data;
          kill_d    = 1'b0;
          cnt_d     = '0;
        end else if (timeout) begin
          valid_d   = !kill_now;
          bus_err_d = !kill_now;
          wb_data_d = '0;
          kill_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  // Outputs: the request is held for the whole REQ state from latched fields.
  always_comb begin
    dmem_req_o   = (state_q == REQ);
    dmem_we_o    = we_q;
    dmem_be_o    = be;
    dmem_addr_o  = {addr_q, 2'b00};
    dmem_wdata_o = wdata;
    valid_o      = valid_q;
    wb_data_o    = wb_data_q;
    rd_o         = rd_q;
    pc_o         = pc_q;
    bus_err_o    = bus_err_q;
  end

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Misalign flag rides along with the trapped result and drops with valid_o.
  always_comb begin
    misalign_d = misalign_q;
    if (state_q == IDLE) begin
      if (flush_i)           misalign_d = 1'b0;
      else if (accept)       misalign_d = is_mem && misalign_in;
      else if (next_ready_i) misalign_d = 1'b0;
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`endif

endmodule
